// File: rtl/muldiv_ctrl.sv
// Sequencer between the control unit and the multi-cycle mult/div units.
// It latches the operands, launches the selected unit, waits out its latency and captures HI/LO.
module muldiv_ctrl #(
  parameter int unsigned MULT_LAT = 34,
  parameter int unsigned DIV_LAT  = 33,
  parameter int unsigned CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_div,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        abort,
  input  logic        rd_hilo,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mult_init,
  output logic        mult_stop,
  output logic        div_init,
  output logic        div_stop,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_done;
  logic             r_div0;
  logic             r_mult_stop;
  logic             r_div_stop;

  logic             w_accept;
  logic             w_reject;
  logic             w_capture;
  logic             w_cancel;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Abort is checked before counter expiry so a flush wins over a same-edge capture.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    w_capture = 1'b0;
    w_cancel  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          if (op_div && (b_in == '0)) begin
            w_reject = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          w_cancel = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_cancel = 1'b1;
          w_next   = S_IDLE;
        end else if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel       <= 1'b0;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
      r_div0      <= 1'b0;
      r_mult_stop <= 1'b0;
      r_div_stop  <= 1'b0;
    end else begin
      r_done      <= w_capture;
      r_div0      <= w_reject;
      r_mult_stop <= w_cancel & ~r_sel;
      r_div_stop  <= w_cancel &  r_sel;
      // Operands are latched for rejected divides too, matching the request as seen.
      if (w_accept || w_reject) begin
        r_op_a <= a_in;
        r_op_b <= b_in;
        r_sel  <= op_div;
      end
      if (r_state == S_LAUNCH) begin
        r_cnt <= r_sel ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_hi <= r_sel ? div_hi : mult_hi;
        r_lo <= r_sel ? div_lo : mult_lo;
      end
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign mult_init = (r_state == S_LAUNCH) & ~r_sel;
  assign div_init  = (r_state == S_LAUNCH) &  r_sel;
  assign mult_stop = r_mult_stop;
  assign div_stop  = r_div_stop;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign div0      = r_div0;
  assign stall     = rd_hilo & busy;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural mult/div stubs plus an arithmetic reference for HI/LO and timing.
module tb_muldiv_ctrl;
  localparam int MULT_LAT = 34;
  localparam int DIV_LAT  = 33;

  logic        clk = 1'b0;
  logic        rst, start, op_div, abort, rd_hilo;
  logic [31:0] a_in, b_in;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [31:0] op_a, op_b, hi, lo;
  logic        mult_init, mult_stop, div_init, div_stop, busy, done, div0, stall;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_hi = '0, ref_lo = '0, last_a = '0, last_b = '0;

  muldiv_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .a_in(a_in), .b_in(b_in),
    .abort(abort), .rd_hilo(rd_hilo), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo), .op_a(op_a), .op_b(op_b),
    .mult_init(mult_init), .mult_stop(mult_stop), .div_init(div_init), .div_stop(div_stop),
    .busy(busy), .done(done), .div0(div0), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Unit stubs: results become valid LAT cycles after init is seen, X before.
  logic               m_run = 1'b0, d_run = 1'b0;
  int                 m_cnt = 0, d_cnt = 0;
  logic signed [31:0] m_a, m_b, d_a, d_b, d_q, d_r;
  logic        [63:0] m_prod;

  always @(posedge clk) begin
    if (mult_init) begin m_run <= 1'b1; m_cnt <= 0; m_a <= op_a; m_b <= op_b; end
    else if (m_run && m_cnt < 1000) m_cnt <= m_cnt + 1;
    if (div_init) begin d_run <= 1'b1; d_cnt <= 0; d_a <= op_a; d_b <= op_b; end
    else if (d_run && d_cnt < 1000) d_cnt <= d_cnt + 1;
  end

  assign m_prod  = {{32{m_a[31]}}, m_a} * {{32{m_b[31]}}, m_b};
  assign d_q     = d_a / d_b;
  assign d_r     = d_a % d_b;
  assign mult_hi = (m_run && m_cnt >= MULT_LAT) ? m_prod[63:32] : 'x;
  assign mult_lo = (m_run && m_cnt >= MULT_LAT) ? m_prod[31:0]  : 'x;
  assign div_hi  = (d_run && d_cnt >= DIV_LAT)  ? d_r : 'x;
  assign div_lo  = (d_run && d_cnt >= DIV_LAT)  ? d_q : 'x;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input bit div, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint p;
    int     sa, sb;
    sa = a;
    sb = b;
    if (div) begin
      eh = 32'(sa % sb);
      el = 32'(sa / sb);
    end else begin
      p  = longint'(sa) * longint'(sb);
      eh = p[63:32];
      el = p[31:0];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_div = 1'b0; abort = 1'b0; rd_hilo = 1'b0;
    a_in = '0; b_in = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({op_a, op_b, hi, lo} !== '0 ||
        {mult_init, mult_stop, div_init, div_stop, busy, done, div0, stall} !== '0) begin
      failures++;
      $display("FAIL reset: op_a=%h op_b=%h hi=%h lo=%h ctl=%b expected all zero", op_a, op_b, hi, lo,
               {mult_init, mult_stop, div_init, div_stop, busy, done, div0, stall});
    end
  endtask

  // Full operation; optionally holds rd_hilo and re-pulses start at observation index repulse.
  task automatic run_op(input bit div, input logic [31:0] a, input logic [31:0] b,
                        input bit hilo_read, input int repulse);
    int          lat, k, n_mi, n_di;
    bit          bad_ops, bad_busy, bad_stall;
    logic [31:0] eh, el;
    lat = div ? DIV_LAT : MULT_LAT;
    model(div, a, b, eh, el);
    n_mi = 0; n_di = 0; bad_ops = 0; bad_busy = 0; bad_stall = 0;
    start = 1'b1; op_div = div; a_in = a; b_in = b; rd_hilo = hilo_read;
    tick();
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    k = 0;
    forever begin
      if (mult_init) n_mi++;
      if (div_init)  n_di++;
      if (op_a !== a || op_b !== b) bad_ops = 1;
      if (busy !== (k < lat + 2)) bad_busy = 1;
      if (stall !== (hilo_read && (k < lat + 2))) bad_stall = 1;
      if (done === 1'b1 || k > lat + 6) break;
      start = (k == repulse); op_div = ~div;
      k++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (k != lat + 2) begin
      failures++;
      $display("FAIL done_latency: got %0d cycles required %0d (div=%0d)", k, lat + 2, div);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL result: div=%0d a=%h b=%h hi=%h lo=%h required hi=%h lo=%h", div, a, b, hi, lo, eh, el);
    end
    checks++;
    if (n_mi != (div ? 0 : 1) || n_di != (div ? 1 : 0)) begin
      failures++;
      $display("FAIL init_pulses: mult_init=%0d div_init=%0d cycles, div=%0d", n_mi, n_di, div);
    end
    checks++;
    if (bad_ops || bad_busy || bad_stall || div0 !== 1'b0) begin
      failures++;
      $display("FAIL hold_busy_stall: ops_bad=%0d busy_bad=%0d stall_bad=%0d div0=%b required 0 0 0 0",
               bad_ops, bad_busy, bad_stall, div0);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_width: done=%b busy=%b required 0 0", done, busy);
    end
    rd_hilo = 1'b0;
    ref_hi = eh; ref_lo = el; last_a = a; last_b = b;
  endtask

  task automatic test_mult();
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, -1);
  endtask

  task automatic test_div();
    run_op(1'b1, 32'd100, 32'd7, 1'b0, -1);
  endtask

  task automatic test_div0();
    start = 1'b1; op_div = 1'b1; a_in = 32'd5; b_in = '0;
    tick();
    start = 1'b0;
    checks++;
    if (div0 !== 1'b1 || busy !== 1'b0 || div_init !== 1'b0 || done !== 1'b0 ||
        hi !== ref_hi || lo !== ref_lo) begin
      failures++;
      $display("FAIL div0_pulse: div0=%b busy=%b div_init=%b done=%b hi=%h lo=%h required 1 0 0 0 %h %h",
               div0, busy, div_init, done, hi, lo, ref_hi, ref_lo);
    end
    checks++;
    if (op_a !== 32'd5 || op_b !== 32'd0) begin
      failures++;
      $display("FAIL div0_latch: op_a=%h op_b=%h required 5 0", op_a, op_b);
    end
    tick();
    checks++;
    if (div0 !== 1'b0 || busy !== 1'b0 || div_init !== 1'b0) begin
      failures++;
      $display("FAIL div0_width: div0=%b busy=%b div_init=%b required 0 0 0", div0, busy, div_init);
    end
    last_a = 32'd5; last_b = '0;
  endtask

  // abort raised after observation abort_k, so it is sampled on the following edge.
  task automatic test_abort(input bit div, input int abort_k);
    logic [31:0] a, b;
    bit          bad;
    a = $urandom; b = $urandom | 32'd1;
    start = 1'b1; op_div = div; a_in = a; b_in = b;
    tick();
    start = 1'b0;
    for (int k = 0; k < abort_k; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (mult_stop !== !div || div_stop !== div || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_k%0d: mult_stop=%b div_stop=%b busy=%b done=%b required %b %b 0 0",
               abort_k, mult_stop, div_stop, busy, done, !div, div);
    end
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mult_stop || div_stop || done || busy) bad = 1;
    end
    checks++;
    if (bad || hi !== ref_hi || lo !== ref_lo) begin
      failures++;
      $display("FAIL abort_after_k%0d: stray_pulse=%0d hi=%h lo=%h required 0 %h %h",
               abort_k, bad, hi, lo, ref_hi, ref_lo);
    end
    last_a = a; last_b = b;
  endtask

  task automatic test_abort_idle();
    start = 1'b1; abort = 1'b1; op_div = 1'b0; a_in = 32'h1234_5678; b_in = 32'h9;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || mult_stop !== 1'b0 || div_stop !== 1'b0 || op_a !== last_a || op_b !== last_b) begin
      failures++;
      $display("FAIL abort_idle: busy=%b stops=%b%b op_a=%h op_b=%h required 0 00 %h %h",
               busy, mult_stop, div_stop, op_a, op_b, last_a, last_b);
    end
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, $urandom, $urandom, 1'b1, 12);
  endtask

  task automatic test_rst_mid();
    bit bad;
    start = 1'b1; op_div = 1'b0; a_in = $urandom; b_in = $urandom;
    tick();
    start = 1'b0;
    for (int k = 0; k < 19; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({op_a, op_b, hi, lo} !== '0 ||
        {mult_init, mult_stop, div_init, div_stop, busy, done, div0, stall} !== '0) begin
      failures++;
      $display("FAIL rst_mid: op_a=%h op_b=%h hi=%h lo=%h ctl=%b required all zero", op_a, op_b, hi, lo,
               {mult_init, mult_stop, div_init, div_stop, busy, done, div0, stall});
    end
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (mult_stop || div_stop || done || busy) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rst_mid_quiet: stray pulse or busy after reset, required none");
    end
    ref_hi = '0; ref_lo = '0;
    run_op(1'b0, 32'd2, 32'd3, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit          div;
    for (int i = 0; i < 10; i++) begin
      div = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 30);
      if (div && (b == '0 || b == '1)) b = 32'd3;
      run_op(div, a, b, $urandom_range(0, 1), $urandom_range(0, 1) ? $urandom_range(1, 30) : -1);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_abort(1'b0, 10);
    test_abort(1'b1, 0);
    test_abort(1'b0, MULT_LAT + 1);
    test_abort(1'b1, DIV_LAT + 1);
    test_abort_idle();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
